// File: rtl/spi_slave_24bit_regif_if.sv
// SPI pin bundle between an external master and the 24-bit register-interface slave.
interface spi_slave_24bit_regif_if;
    logic cs;
    logic mosi;
    logic miso;

    modport master (output cs, output mosi, input miso);
    modport slave  (input cs, input mosi, output miso);
endinterface

// File: rtl/spi_slave_24bit_regif.sv
// SPI mode-0 slave: fixed R/W + address + data frames, MSB first, backed by a register file.
module spi_slave_24bit_regif #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic                     sclk,
    input  logic                     rst,
    spi_slave_24bit_regif_if.slave   spi,
    output logic [ADDR_W+DATA_W:0]   data_in_test,
    output logic [7:0]               counter_sclk,
    output logic                     latch_data_write,
    output logic [ADDR_W:0]          raddr,
    output logic                     start_tranmist
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int IDX_W   = $clog2(DATA_W);
    localparam logic [7:0] ADDR_DONE = 8'(ADDR_W);
    localparam logic [7:0] TX_FIRST  = 8'(ADDR_W + 1);
    localparam logic [7:0] TX_LAST   = 8'(FRAME_W - 1);

    logic [DATA_W-1:0] regs [2**ADDR_W];
    logic [DATA_W-1:0] rdata;
    logic              frame_on;
    logic              addr_edge;
    logic              rw_at_addr;
    logic              wr_commit;
    logic              tx_window;
    logic [ADDR_W-1:0] addr_rx;
    logic [IDX_W-1:0]  tx_idx;

    assign frame_on   = ~spi.cs;
    // Conditions are evaluated on the pre-shift contents, so the bit arriving on mosi is appended.
    assign addr_edge  = (counter_sclk == ADDR_DONE);
    assign rw_at_addr = data_in_test[ADDR_W-1];
    assign addr_rx    = {data_in_test[ADDR_W-2:0], spi.mosi};
    assign wr_commit  = (counter_sclk == TX_LAST) && !data_in_test[FRAME_W-2];
    assign tx_window  = start_tranmist && (counter_sclk >= TX_FIRST) && (counter_sclk <= TX_LAST);
    assign tx_idx     = IDX_W'(TX_LAST - counter_sclk);

    always_ff @(posedge sclk or posedge rst or posedge spi.cs) begin
        if (rst) begin
            counter_sclk     <= '0;
            start_tranmist   <= 1'b0;
            latch_data_write <= 1'b0;
        end else if (spi.cs) begin
            counter_sclk     <= '0;
            start_tranmist   <= 1'b0;
            latch_data_write <= 1'b0;
        end else begin
            if (counter_sclk != '1)
                counter_sclk <= counter_sclk + 8'd1;
            if (addr_edge && rw_at_addr)
                start_tranmist <= 1'b1;
            latch_data_write <= wr_commit;
        end
    end

    // Shift register, address and register file survive cs; only rst clears them.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            data_in_test <= '0;
            raddr        <= '0;
            rdata        <= '0;
            for (int unsigned i = 0; i < 2**ADDR_W; i++)
                regs[i] <= '0;
        end else if (frame_on) begin
            data_in_test <= {data_in_test[FRAME_W-2:0], spi.mosi};
            if (addr_edge) begin
                raddr <= {1'b0, addr_rx};
                if (rw_at_addr)
                    rdata <= regs[addr_rx];
            end
            if (wr_commit)
                regs[raddr[ADDR_W-1:0]] <= {data_in_test[DATA_W-2:0], spi.mosi};
        end
    end

    always_ff @(negedge sclk or posedge rst or posedge spi.cs) begin
        if (rst)
            spi.miso <= 1'b0;
        else if (spi.cs)
            spi.miso <= 1'b0;
        else
            spi.miso <= tx_window ? rdata[tx_idx] : 1'b0;
    end
endmodule

// File: tb/tb_spi_slave_24bit_regif.sv
// Scoreboard bench for spi_slave_24bit_regif: frames driven bit by bit, read bits queued and compared.
module tb_spi_slave_24bit_regif;
    logic        sclk = 1'b0;
    logic        rst  = 1'b0;
    logic [23:0] data_in_test;
    logic [7:0]  counter_sclk;
    logic        latch_data_write;
    logic [7:0]  raddr;
    logic        start_tranmist;

    spi_slave_24bit_regif_if spi_bus ();

    spi_slave_24bit_regif #(.ADDR_W(7), .DATA_W(16)) dut (
        .sclk             (sclk),
        .rst              (rst),
        .spi              (spi_bus),
        .data_in_test     (data_in_test),
        .counter_sclk     (counter_sclk),
        .latch_data_write (latch_data_write),
        .raddr            (raddr),
        .start_tranmist   (start_tranmist)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        exp_q[$];
    logic [15:0] mdl [128];
    logic [23:0] cur_frame;
    int          edge_no;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic fbit(input int i);
        logic [23:0] f;
        f = cur_frame;
        return (i < 24) ? f[5'(23 - i)] : 1'b0;
    endfunction

    // One sclk period; read bits are sampled just before rising edges 9..24.
    task automatic clock_bit(input logic b);
        logic e;
        spi_bus.mosi = b;
        #5;
        if (cur_frame[23] && edge_no >= 8 && edge_no <= 23) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("miso_bit", 32'(spi_bus.miso), 32'(e));
            end else begin
                check_eq("rd_queue_underflow", 32'(exp_q.size()), 32'd1);
            end
        end
        sclk = 1'b1;
        edge_no++;
        if (edge_no == 24 && !cur_frame[23])
            mdl[cur_frame[22:16]] = cur_frame[15:0];
        #5 sclk = 1'b0;
        #5;
    endtask

    task automatic begin_frame(input logic [23:0] f);
        cur_frame = f;
        edge_no   = 0;
        exp_q.delete();
        if (f[23])
            for (int i = 15; i >= 0; i--)
                exp_q.push_back(mdl[f[22:16]][i]);
        spi_bus.cs = 1'b0;
        #5;
    endtask

    task automatic end_frame();
        #5 spi_bus.cs = 1'b1;
        #5;
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++)
            clock_bit(fbit(i));
    endtask

    task automatic do_read(input logic [6:0] a);
        begin_frame({1'b1, a, 16'h0000});
        send_bits(24);
        check_eq("rd_drain", 32'(exp_q.size()), 32'd0);
        end_frame();
    endtask

    initial begin
        spi_bus.cs   = 1'b1;
        spi_bus.mosi = 1'b0;
        cur_frame    = '0;
        edge_no      = 0;
        for (int i = 0; i < 128; i++) mdl[i] = '0;

        rst = 1'b1;
        #10;
        check_eq("rst_miso",  32'(spi_bus.miso), 0);
        check_eq("rst_data",  32'(data_in_test), 0);
        check_eq("rst_cnt",   32'(counter_sclk), 0);
        check_eq("rst_latch", 32'(latch_data_write), 0);
        check_eq("rst_raddr", 32'(raddr), 0);
        check_eq("rst_start", 32'(start_tranmist), 0);
        rst = 1'b0;
        #10;
        do_read(7'h11);

        // Alternating read frame with one extra edge
        begin_frame(24'hAAAAAA);
        for (int i = 0; i < 25; i++) begin
            clock_bit(i % 2 == 0);
            if (edge_no == 8) begin
                check_eq("alt_raddr", 32'(raddr), 32'h2A);
                check_eq("alt_start", 32'(start_tranmist), 1);
            end
            if (edge_no == 24) begin
                check_eq("alt_data",  32'(data_in_test), 32'hAAAAAA);
                check_eq("alt_latch24", 32'(latch_data_write), 0);
            end
            if (edge_no == 25) begin
                check_eq("alt_cnt25", 32'(counter_sclk), 25);
                check_eq("alt_latch25", 32'(latch_data_write), 0);
            end
        end
        check_eq("rd_drain", 32'(exp_q.size()), 32'd0);
        end_frame();
        check_eq("cs_cnt",   32'(counter_sclk), 0);
        check_eq("cs_start", 32'(start_tranmist), 0);
        check_eq("cs_miso",  32'(spi_bus.miso), 0);
        check_eq("cs_data_held",  32'(data_in_test), 32'h555555);
        check_eq("cs_raddr_held", 32'(raddr), 32'h2A);

        // Write 0x05 = 0xBEEF
        begin_frame(24'h05BEEF);
        for (int i = 0; i < 24; i++) begin
            clock_bit(fbit(i));
            if (edge_no == 8)  check_eq("wr_start8", 32'(start_tranmist), 0);
            if (edge_no == 23) check_eq("wr_latch23", 32'(latch_data_write), 0);
            if (edge_no == 24) begin
                check_eq("wr_latch24", 32'(latch_data_write), 1);
                check_eq("wr_start24", 32'(start_tranmist), 0);
            end
        end
        end_frame();
        check_eq("wr_latch_cs", 32'(latch_data_write), 0);

        // Write 0x07 = 0x5A5A, latch drops on the next rising edge
        begin_frame(24'h075A5A);
        for (int i = 0; i < 25; i++) begin
            clock_bit(fbit(i));
            if (edge_no == 24) check_eq("wr7_latch24", 32'(latch_data_write), 1);
            if (edge_no == 25) check_eq("wr7_latch25", 32'(latch_data_write), 0);
        end
        end_frame();

        // Read back 0x05
        begin_frame(24'h850000);
        for (int i = 0; i < 24; i++) begin
            clock_bit(fbit(i));
            if (edge_no == 8) check_eq("rd5_raddr", 32'(raddr), 32'h05);
        end
        check_eq("rd5_miso_idle", 32'(spi_bus.miso), 0);
        check_eq("rd_drain", 32'(exp_q.size()), 32'd0);
        end_frame();
        do_read(7'h07);

        // Aborted write to 0x07 after 12 edges
        begin_frame(24'h071234);
        for (int i = 0; i < 12; i++) begin
            clock_bit(fbit(i));
            check_eq("abort_latch", 32'(latch_data_write), 0);
        end
        end_frame();
        check_eq("abort_cnt", 32'(counter_sclk), 0);
        do_read(7'h07);

        // Long write frame: counter saturates, nothing after edge 24 commits
        begin_frame(24'h031111);
        for (int i = 0; i < 260; i++) begin
            clock_bit(fbit(i));
            if (edge_no == 25) check_eq("long_latch25", 32'(latch_data_write), 0);
        end
        check_eq("long_cnt_sat", 32'(counter_sclk), 255);
        check_eq("long_raddr",   32'(raddr), 32'h03);
        end_frame();
        do_read(7'h03);

        // Reset in the middle of a read
        begin_frame(24'h850000);
        send_bits(12);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_miso",  32'(spi_bus.miso), 0);
        check_eq("mid_rst_start", 32'(start_tranmist), 0);
        check_eq("mid_rst_cnt",   32'(counter_sclk), 0);
        check_eq("mid_rst_raddr", 32'(raddr), 0);
        check_eq("mid_rst_data",  32'(data_in_test), 0);
        exp_q.delete();
        for (int i = 0; i < 128; i++) mdl[i] = '0;
        #5 rst = 1'b0;
        end_frame();
        do_read(7'h05);
        do_read(7'h07);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
